// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve queue: branch opcodes,
// {predicted, actual} update codes and the in-flight branch entry.
package branch_pkg;

  // Conditional branch opcodes, taken from instruction bits [0:5]
  localparam logic [0:5] OP_BR0 = 6'b100010;
  localparam logic [0:5] OP_BR1 = 6'b100011;

  // {predicted, actual} codes the predictor trains on
  localparam logic [0:1] PA_NT_T = 2'b01;
  localparam logic [0:1] PA_T_NT = 2'b10;

  // PC width held in an entry; narrower PC_W values are zero-extended
  localparam int BR_PC_W = 32;

  typedef struct packed {
    logic [0:31]        instr;
    logic [0:BR_PC_W-1] pc;
    logic               pred;
  } br_entry_t;

  function automatic logic is_branch_op(input logic [0:5] op);
    return (op == OP_BR0) || (op == OP_BR1);
  endfunction

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch / resolve / predictor-update bundle for branch_resolve_queue.
// Optional stats outputs appear when BRQ_STATS_EN is defined.
interface branch_resolve_queue_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
);
  localparam int CW = $clog2(DEPTH);

  logic              fetch_valid;
  logic [0:31]       fetch_instr;
  logic [0:PC_W-1]   fetch_pc;
  logic              fetch_pred;
  logic              fetch_stall;
  logic              resolve_valid;
  logic              resolve_taken;
  logic [0:PC_W-1]   resolve_target;
  logic [0:31]       upd_instr;
  logic [0:1]        pred_actual;
  logic              mispredict;
  logic [0:PC_W-1]   redirect_pc;
  logic [0:CW]       count;
  logic              underflow_err;
`ifdef BRQ_STATS_EN
  logic [0:15]       stat_branches;
  logic [0:15]       stat_mispredicts;
`endif

  // Driven by fetch/execute (and the bench)
  modport master (
`ifdef BRQ_STATS_EN
    input  stat_branches, stat_mispredicts,
`endif
    output fetch_valid, fetch_instr, fetch_pc, fetch_pred,
    output resolve_valid, resolve_taken, resolve_target,
    input  fetch_stall, upd_instr, pred_actual, mispredict,
    input  redirect_pc, count, underflow_err
  );

  // The queue itself
  modport slave (
`ifdef BRQ_STATS_EN
    output stat_branches, stat_mispredicts,
`endif
    input  fetch_valid, fetch_instr, fetch_pc, fetch_pred,
    input  resolve_valid, resolve_taken, resolve_target,
    output fetch_stall, upd_instr, pred_actual, mispredict,
    output redirect_pc, count, underflow_err
  );

endinterface

// File: rtl/brq_fifo.sv
// Branch entry storage: circular buffer with head/tail pointers, an
// occupancy count and a synchronous flush. full/empty come from count.
module brq_fifo
  import branch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  br_entry_t              push_entry,
  output br_entry_t              head_entry,
  output logic [0:$clog2(DEPTH)] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  br_entry_t        mem_reg [DEPTH];
  logic [AW-1:0]    head_reg, tail_reg;
  logic [0:AW]      count_reg;
  logic [DEPTH-1:0] wr_en;
  logic             do_pop, do_push;

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // A pop frees a slot, so a full queue may accept a push in the same
  // cycle; a flush discards any same-cycle push.
  assign do_pop  = pop && !empty;
  assign do_push = push && !flush && (!full || do_pop);

  assign head_entry = mem_reg[head_reg];

  // One-hot write enable for the tail slot
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = do_push && (tail_reg == AW'(gi));
  end

  // Entry payload; validity is implied by count, so no reset needed
  always_ff @(posedge Clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) mem_reg[i] <= push_entry;
    end
  end

  // Pointers and occupancy; power-of-2 DEPTH lets pointers wrap naturally
  always_ff @(posedge Clock) begin
    if (Reset || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_pop)  head_reg <= head_reg + AW'(1);
      if (do_push) tail_reg <= tail_reg + AW'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + (AW+1)'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// Tracks in-flight conditional branches from fetch to execute and emits
// predictor updates plus a one-cycle mispredict redirect/flush.
// Optional feature: define BRQ_STATS_EN for saturating resolve/mispredict
// counters (stat_branches, stat_mispredicts).
module branch_resolve_queue
  import branch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                  Clock,
  input  logic                  Reset,
  branch_resolve_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH);

  br_entry_t       push_entry, head_entry;
  logic [0:CW]     fifo_count;
  logic            fifo_full, fifo_empty;
  logic            is_branch, do_pop, mis_now;
  logic [0:PC_W-1] head_pc, redirect_next;

  logic [0:31]     upd_instr_reg;
  logic [0:1]      pred_actual_reg;
  logic            mispredict_reg;
  logic [0:PC_W-1] redirect_pc_reg;
  logic            underflow_reg;

  // Branch detect, resolve compare and redirect target
  always_comb begin
    is_branch        = is_branch_op(bus.fetch_instr[0:5]);
    push_entry.instr = bus.fetch_instr;
    push_entry.pc    = BR_PC_W'(bus.fetch_pc);
    push_entry.pred  = bus.fetch_pred;
    do_pop           = bus.resolve_valid && !fifo_empty;
    mis_now          = do_pop && (head_entry.pred != bus.resolve_taken);
    head_pc          = PC_W'(head_entry.pc);
    redirect_next    = bus.resolve_taken ? bus.resolve_target
                                         : head_pc + PC_W'(4);
  end

  brq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clock      (Clock),
    .Reset      (Reset),
    .push       (bus.fetch_valid && is_branch),
    .pop        (do_pop),
    .flush      (mis_now),
    .push_entry (push_entry),
    .head_entry (head_entry),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Registered predictor update and redirect; codes return to 00 when idle
  always_ff @(posedge Clock) begin
    if (Reset) begin
      upd_instr_reg   <= '0;
      pred_actual_reg <= '0;
      mispredict_reg  <= 1'b0;
      redirect_pc_reg <= '0;
      underflow_reg   <= 1'b0;
    end else begin
      pred_actual_reg <= do_pop ? {head_entry.pred, bus.resolve_taken} : 2'b00;
      mispredict_reg  <= mis_now;
      if (do_pop)  upd_instr_reg   <= head_entry.instr;
      if (mis_now) redirect_pc_reg <= redirect_next;
      if (bus.resolve_valid && fifo_empty) underflow_reg <= 1'b1;
    end
  end

  assign bus.fetch_stall   = fifo_full;
  assign bus.count         = fifo_count;
  assign bus.upd_instr     = upd_instr_reg;
  assign bus.pred_actual   = pred_actual_reg;
  assign bus.mispredict    = mispredict_reg;
  assign bus.redirect_pc   = redirect_pc_reg;
  assign bus.underflow_err = underflow_reg;

`ifdef BRQ_STATS_EN
  logic [0:15] stat_br_reg, stat_mis_reg;

  // Saturating resolve and mispredict counters
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stat_br_reg  <= '0;
      stat_mis_reg <= '0;
    end else begin
      if (do_pop && stat_br_reg != 16'hFFFF)   stat_br_reg  <= stat_br_reg + 16'd1;
      if (mis_now && stat_mis_reg != 16'hFFFF) stat_mis_reg <= stat_mis_reg + 16'd1;
    end
  end

  assign bus.stat_branches    = stat_br_reg;
  assign bus.stat_mispredicts = stat_mis_reg;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue (DEPTH=4, PC_W=32).
module tb_branch_resolve_queue;
  import branch_pkg::*;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  branch_resolve_queue_if #(.DEPTH(4), .PC_W(32)) bus ();

  branch_resolve_queue #(.DEPTH(4), .PC_W(32)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
    $display("t=%0t fv=%b instr=%h pred=%b rv=%b rt=%b | count=%0d stall=%b pa=%b mis=%b rpc=%h upd=%h uf=%b",
             $time, bus.fetch_valid, bus.fetch_instr, bus.fetch_pred, bus.resolve_valid,
             bus.resolve_taken, bus.count, bus.fetch_stall, bus.pred_actual, bus.mispredict,
             bus.redirect_pc, bus.upd_instr, bus.underflow_err);
  endtask

  task automatic idle();
    bus.fetch_valid    = 1'b0;
    bus.fetch_instr    = '0;
    bus.fetch_pc       = '0;
    bus.fetch_pred     = 1'b0;
    bus.resolve_valid  = 1'b0;
    bus.resolve_taken  = 1'b0;
    bus.resolve_target = '0;
  endtask

  task automatic set_fetch(input logic [0:31] instr, input logic [0:31] pc, input logic pred);
    bus.fetch_valid = 1'b1;
    bus.fetch_instr = instr;
    bus.fetch_pc    = pc;
    bus.fetch_pred  = pred;
  endtask

  task automatic set_resolve(input logic taken, input logic [0:31] target);
    bus.resolve_valid  = 1'b1;
    bus.resolve_taken  = taken;
    bus.resolve_target = target;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    idle();
    tick();
    tick();
    checks++;
    if (bus.count !== 3'd0 || bus.fetch_stall !== 1'b0 || bus.pred_actual !== 2'b00 ||
        bus.mispredict !== 1'b0 || bus.redirect_pc !== 32'h0 || bus.upd_instr !== 32'h0 ||
        bus.underflow_err !== 1'b0) begin
      $display("FAIL reset_outputs got count=%0d stall=%b pa=%b mis=%b rpc=%h upd=%h uf=%b expected all zero",
               bus.count, bus.fetch_stall, bus.pred_actual, bus.mispredict,
               bus.redirect_pc, bus.upd_instr, bus.underflow_err);
      failures++;
    end
    Reset = 1'b0;
  endtask

  task automatic test_simple_mispredict();
    set_fetch(32'h88000003, 32'h100, 1'b1);
    tick();
    checks++;
    if (bus.count !== 3'd1) begin
      $display("FAIL simple_enq_count got=%0d expected=1", bus.count); failures++;
    end
    idle();
    set_resolve(1'b0, 32'h0);
    tick();
    checks++;
    if (bus.pred_actual !== PA_T_NT) begin
      $display("FAIL simple_pa got=%b expected=10", bus.pred_actual); failures++;
    end
    checks++;
    if (bus.mispredict !== 1'b1) begin
      $display("FAIL simple_mis got=%b expected=1", bus.mispredict); failures++;
    end
    checks++;
    if (bus.redirect_pc !== 32'h104) begin
      $display("FAIL simple_redirect got=%h expected=00000104", bus.redirect_pc); failures++;
    end
    checks++;
    if (bus.upd_instr !== 32'h88000003) begin
      $display("FAIL simple_upd got=%h expected=88000003", bus.upd_instr); failures++;
    end
    checks++;
    if (bus.count !== 3'd0) begin
      $display("FAIL simple_count got=%0d expected=0", bus.count); failures++;
    end
    idle();
    tick();
    checks++;
    if (bus.pred_actual !== 2'b00 || bus.mispredict !== 1'b0 || bus.upd_instr !== 32'h88000003) begin
      $display("FAIL simple_idle got pa=%b mis=%b upd=%h expected pa=00 mis=0 upd=88000003",
               bus.pred_actual, bus.mispredict, bus.upd_instr);
      failures++;
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      set_fetch(32'h8C000010 + i, 32'h400 + 4 * i, 1'b0);
      tick();
    end
    checks++;
    if (bus.count !== 3'd4 || bus.fetch_stall !== 1'b1) begin
      $display("FAIL fill_full got count=%0d stall=%b expected count=4 stall=1", bus.count, bus.fetch_stall);
      failures++;
    end
    set_fetch(32'h88000055, 32'h410, 1'b0);
    tick();
    checks++;
    if (bus.count !== 3'd4) begin
      $display("FAIL fill_fifth_dropped got count=%0d expected=4", bus.count); failures++;
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      set_resolve(1'b0, 32'h0);
      tick();
      checks++;
      if (bus.pred_actual !== 2'b00 || bus.mispredict !== 1'b0 || bus.upd_instr !== (32'h8C000010 + i)) begin
        $display("FAIL drain_%0d got pa=%b mis=%b upd=%h expected pa=00 mis=0 upd=%h",
                 i, bus.pred_actual, bus.mispredict, bus.upd_instr, 32'h8C000010 + i);
        failures++;
      end
    end
    idle();
    checks++;
    if (bus.count !== 3'd0 || bus.fetch_stall !== 1'b0) begin
      $display("FAIL drain_empty got count=%0d stall=%b expected count=0 stall=0", bus.count, bus.fetch_stall);
      failures++;
    end
  endtask

  task automatic test_flush_same_cycle();
    for (int i = 0; i < 3; i++) begin
      set_fetch(32'h88000020 + i, 32'h300 + 4 * i, 1'b0);
      tick();
    end
    set_fetch(32'h88000099, 32'h30C, 1'b0);
    set_resolve(1'b1, 32'h200);
    tick();
    checks++;
    if (bus.pred_actual !== PA_NT_T || bus.mispredict !== 1'b1) begin
      $display("FAIL flush_pa_mis got pa=%b mis=%b expected pa=01 mis=1", bus.pred_actual, bus.mispredict);
      failures++;
    end
    checks++;
    if (bus.redirect_pc !== 32'h200 || bus.upd_instr !== 32'h88000020) begin
      $display("FAIL flush_redirect got rpc=%h upd=%h expected rpc=00000200 upd=88000020",
               bus.redirect_pc, bus.upd_instr);
      failures++;
    end
    checks++;
    if (bus.count !== 3'd0) begin
      $display("FAIL flush_count got=%0d expected=0", bus.count); failures++;
    end
    idle();
    tick();
    checks++;
    if (bus.mispredict !== 1'b0 || bus.count !== 3'd0) begin
      $display("FAIL flush_pulse got mis=%b count=%0d expected mis=0 count=0", bus.mispredict, bus.count);
      failures++;
    end
  endtask

  task automatic test_nonbranch_underflow();
    set_fetch(32'h88000030, 32'h500, 1'b0);
    tick();
    set_fetch(32'h04000000, 32'h504, 1'b0);
    tick();
    checks++;
    if (bus.count !== 3'd1) begin
      $display("FAIL nonbranch_count got=%0d expected=1", bus.count); failures++;
    end
    idle();
    set_resolve(1'b0, 32'h0);
    tick();
    checks++;
    if (bus.count !== 3'd0 || bus.upd_instr !== 32'h88000030 || bus.underflow_err !== 1'b0) begin
      $display("FAIL nonbranch_pop got count=%0d upd=%h uf=%b expected count=0 upd=88000030 uf=0",
               bus.count, bus.upd_instr, bus.underflow_err);
      failures++;
    end
    set_resolve(1'b1, 32'h123);
    tick();
    checks++;
    if (bus.underflow_err !== 1'b1 || bus.pred_actual !== 2'b00 || bus.mispredict !== 1'b0) begin
      $display("FAIL underflow got uf=%b pa=%b mis=%b expected uf=1 pa=00 mis=0",
               bus.underflow_err, bus.pred_actual, bus.mispredict);
      failures++;
    end
    idle();
    tick();
    checks++;
    if (bus.underflow_err !== 1'b1) begin
      $display("FAIL underflow_sticky got=%b expected=1", bus.underflow_err); failures++;
    end
    // Enqueue and resolve together into an empty queue: the resolve sees empty
    set_fetch(32'h8C000040, 32'h600, 1'b1);
    set_resolve(1'b1, 32'h700);
    tick();
    checks++;
    if (bus.count !== 3'd1 || bus.pred_actual !== 2'b00 || bus.mispredict !== 1'b0) begin
      $display("FAIL enq_resolve_empty got count=%0d pa=%b mis=%b expected count=1 pa=00 mis=0",
               bus.count, bus.pred_actual, bus.mispredict);
      failures++;
    end
    idle();
    set_resolve(1'b1, 32'h700);
    tick();
    checks++;
    if (bus.pred_actual !== 2'b11 || bus.mispredict !== 1'b0 || bus.upd_instr !== 32'h8C000040 ||
        bus.count !== 3'd0) begin
      $display("FAIL late_resolve got pa=%b mis=%b upd=%h count=%0d expected pa=11 mis=0 upd=8c000040 count=0",
               bus.pred_actual, bus.mispredict, bus.upd_instr, bus.count);
      failures++;
    end
    idle();
  endtask

  task automatic test_full_swap();
    logic [0:31] model_q[$];
    logic [0:31] exp_instr;
    logic [0:31] new_instr;
    for (int i = 0; i < 4; i++) begin
      set_fetch(32'h88000100 + i, 32'h800 + 4 * i, 1'b1);
      model_q.push_back(32'h88000100 + i);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      new_instr = 32'h88000200 + k;
      set_fetch(new_instr, 32'h900 + 4 * k, 1'b1);
      set_resolve(1'b1, 32'hA00);
      tick();
      exp_instr = model_q.pop_front();
      model_q.push_back(new_instr);
      checks++;
      if (bus.count !== 3'd4 || bus.fetch_stall !== 1'b1 || bus.upd_instr !== exp_instr ||
          bus.pred_actual !== 2'b11 || bus.mispredict !== 1'b0) begin
        $display("FAIL swap_%0d got count=%0d stall=%b upd=%h pa=%b mis=%b expected count=4 stall=1 upd=%h pa=11 mis=0",
                 k, bus.count, bus.fetch_stall, bus.upd_instr, bus.pred_actual, bus.mispredict, exp_instr);
        failures++;
      end
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      set_resolve(1'b1, 32'hA00);
      tick();
      exp_instr = model_q.pop_front();
      checks++;
      if (bus.upd_instr !== exp_instr || bus.mispredict !== 1'b0) begin
        $display("FAIL swap_drain_%0d got upd=%h mis=%b expected upd=%h mis=0",
                 i, bus.upd_instr, bus.mispredict, exp_instr);
        failures++;
      end
    end
    idle();
    checks++;
    if (bus.count !== 3'd0) begin
      $display("FAIL swap_end_count got=%0d expected=0", bus.count); failures++;
    end
  endtask

  task automatic test_reset_mid_op();
    set_fetch(32'h88000300, 32'hB00, 1'b1);
    tick();
    set_fetch(32'h88000301, 32'hB04, 1'b1);
    tick();
    idle();
    set_resolve(1'b0, 32'hC00);
    Reset = 1'b1;
    tick();
    checks++;
    if (bus.count !== 3'd0 || bus.fetch_stall !== 1'b0 || bus.pred_actual !== 2'b00 ||
        bus.mispredict !== 1'b0 || bus.redirect_pc !== 32'h0 || bus.upd_instr !== 32'h0 ||
        bus.underflow_err !== 1'b0) begin
      $display("FAIL reset_mid got count=%0d stall=%b pa=%b mis=%b rpc=%h upd=%h uf=%b expected all zero",
               bus.count, bus.fetch_stall, bus.pred_actual, bus.mispredict,
               bus.redirect_pc, bus.upd_instr, bus.underflow_err);
      failures++;
    end
    Reset = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_stats();
    set_fetch(32'h88000400, 32'hD00, 1'b0);
    tick();
    set_fetch(32'h88000401, 32'hD04, 1'b0);
    tick();
    set_fetch(32'h8C000402, 32'hFFFFFFFC, 1'b1);
    tick();
    idle();
    set_resolve(1'b0, 32'h0);
    tick();
    tick();
    checks++;
    if (bus.pred_actual !== 2'b00 || bus.mispredict !== 1'b0 || bus.count !== 3'd1) begin
      $display("FAIL stats_correct got pa=%b mis=%b count=%0d expected pa=00 mis=0 count=1",
               bus.pred_actual, bus.mispredict, bus.count);
      failures++;
    end
    tick();
    checks++;
    if (bus.pred_actual !== PA_T_NT || bus.mispredict !== 1'b1 || bus.redirect_pc !== 32'h0) begin
      $display("FAIL stats_wrap_redirect got pa=%b mis=%b rpc=%h expected pa=10 mis=1 rpc=00000000",
               bus.pred_actual, bus.mispredict, bus.redirect_pc);
      failures++;
    end
    idle();
    tick();
`ifdef BRQ_STATS_EN
    checks++;
    if (bus.stat_branches !== 16'd3 || bus.stat_mispredicts !== 16'd1) begin
      $display("FAIL stats_counts got branches=%0d mispredicts=%0d expected branches=3 mispredicts=1",
               bus.stat_branches, bus.stat_mispredicts);
      failures++;
    end
`endif
  endtask

  initial begin
    idle();
    test_reset();
    test_simple_mispredict();
    test_fill_drain();
    test_flush_same_cycle();
    test_nonbranch_underflow();
    test_full_swap();
    test_reset_mid_op();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

Tracks every in-flight conditional branch from fetch to execute. It holds each branch's fetch-time prediction until execute resolves it, then emits the `{predicted, actual}` update code and instruction word that train the branch predictor. On a mispredict it raises a one-cycle redirect/flush to fetch. It sits between the fetch stage, where predictions are produced, and the predictor's update port.

## Interface
- `DEPTH`, default 4: number of in-flight branch entries; must be a power of 2, minimum 2.
- `PC_W`, default 32: PC width in bits.
- `Clock` in, 1: clock. All state updates on its rising edge.
- `Reset` in, 1: reset, synchronous, active-high.
- `fetch_valid` in, 1: the fetch stage presents an instruction this cycle.
- `fetch_instr` in, [0:31]: fetched instruction word.
- `fetch_pc` in, [0:PC_W-1]: PC of `fetch_instr`.
- `fetch_pred` in, 1: predictor output for `fetch_instr` (1 = taken).
- `fetch_stall` out, 1: queue full; fetch must hold its branch.
- `resolve_valid` in, 1: execute resolves the oldest branch this cycle.
- `resolve_taken` in, 1: actual outcome of that branch.
- `resolve_target` in, [0:PC_W-1]: taken target of that branch.
- `upd_instr` out, [0:31]: instruction word of the resolved branch; drives the predictor's Instruction port.
- `pred_actual` out, [0:1]: `{predicted, actual}`; 2'b00 when idle.
- `mispredict` out, 1: one-cycle pulse; fetch redirects and younger stages flush.
- `redirect_pc` out, [0:PC_W-1]: correct next PC, valid while `mispredict` is high.
- `count` out, [0:$clog2(DEPTH)]: number of occupied entries.
- `underflow_err` out, 1: sticky flag; set when a resolve arrives with the queue empty.

## Operation
- **Branch detect:** `fetch_instr[0:5]` equals 6'b100010 or 6'b100011. Other opcodes are never enqueued.
- **Enqueue:** on `fetch_valid && branch && !full`, write `{instr, pc, pred}` at the tail and increment the tail pointer (mod DEPTH).
- **Resolve:** on `resolve_valid && count != 0`, pop the head.
  - Register `upd_instr` = head instr.
  - Register `pred_actual` = `{head.pred, resolve_taken}`. All four codes are passed through; the predictor acts on 01 and 10 only.
- **Mispredict:** `head.pred != resolve_taken`.
  - Pulse `mispredict` for one cycle.
  - `redirect_pc` = `resolve_target` if taken, else `head.pc + 4`. The add wraps modulo 2^PC_W.
  - The whole queue is flushed: head = tail = 0, count = 0. All younger entries are wrong-path.
- **Enqueue + resolve, same cycle:**
  - Correct prediction: both happen and `count` is unchanged. This is legal when full, because the pop frees a slot. `fetch_stall` still reflects the registered full state and is not combinationally relieved.
  - Mispredict: the enqueue is discarded (wrong path). The queue ends empty.
- **Full:** the enqueue is ignored and the entry is not written. `fetch_stall` = (count == DEPTH), decoded from registered state.
- **Empty resolve:** no pop. `pred_actual` stays 2'b00, `mispredict` stays 0, and `underflow_err` is set. `underflow_err` clears only on Reset.
- **Pointer wrap:** head and tail carry $clog2(DEPTH) bits plus `count`. full/empty are decided by `count` only.

## Timing
- **Reset values:** all outputs 0. head/tail/count 0, entries invalid, `underflow_err` 0. Reset has priority over any same-cycle fetch or resolve; an in-flight operation is dropped.
- **Enqueue latency:** an entry enqueued at edge N is resolvable from cycle N+1. A resolve in the same cycle as the enqueue into an empty queue is an empty resolve.
- **Resolve-to-output latency:** `upd_instr`, `pred_actual`, `mispredict` and `redirect_pc` are registered. They are valid in the cycle after the `resolve_valid` edge, for exactly one cycle.
- **Idle values:** `pred_actual` is 2'b00 and `mispredict` is 0 in every non-resolve cycle. `upd_instr` holds its last value.
- **Back-to-back resolves:** supported at one per cycle.

## Configuration
- **`BRQ_STATS_EN` defined:** adds two outputs, `stat_branches` and `stat_mispredicts`, each [0:15].
  - `stat_branches` increments on every successful resolve.
  - `stat_mispredicts` increments on every mispredict.
  - Both saturate at 16'hFFFF and clear on Reset.
- **`BRQ_STATS_EN` not defined:** the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- **Shared package `branch_pkg`:**
  - opcode constants `OP_BR0` = 6'b100010 and `OP_BR1` = 6'b100011;
  - `pred_actual` encodings `PA_NT_T` = 2'b01 and `PA_T_NT` = 2'b10;
  - a branch entry typedef `{instr, pc, pred}`.
- **Sub-module `brq_fifo`:** the storage array with pointers, count, and a synchronous flush input. The top level holds branch detect, compare, redirect and stats.

## Test plan
- **Simple mispredict:** enqueue a branch 0x88000003 with pred=1 at pc 0x100; resolve taken=0 → next cycle `pred_actual`=10, `mispredict`=1, `redirect_pc`=0x104, `upd_instr`=0x88000003, `count`=0.
- **Fill and drain:** enqueue 4 branches with pred=0, then a 5th → `fetch_stall`=1, 5th dropped, `count`=4. Resolve all 4 not-taken in consecutive cycles → four `pred_actual`=00 cycles, no `mispredict`, `count`=0.
- **Mispredict flush with same-cycle enqueue:** 3 entries queued; resolve the head taken with pred=0, `resolve_target`=0x200, while enqueuing a 4th → `pred_actual`=01, `redirect_pc`=0x200, `count`=0, 4th discarded.
- **Non-branch filtering:** fetch opcode 6'b000001 with `fetch_valid`=1 → `count` unchanged. Resolve on empty queue → `underflow_err`=1, `pred_actual`=00.
- **Full swap:** queue full; enqueue plus correct resolve in the same cycle → `count` stays 4, new entry present at the tail; pointers wrap correctly over 10 iterations.
- **Reset mid-operation and stats:** Reset asserted with 2 entries queued and a resolve pending → all outputs 0 next cycle. With `BRQ_STATS_EN`: 3 resolves including 1 mispredict → `stat_branches`=3, `stat_mispredicts`=1.
